memory_controller: RTL and testbench
====================================

// Module: memory_controller
// PURPOSE
//  Memory-side FSM between the processor core and a byte-wide synchronous RAM.
//  Accepts one load/store request (memory_start pulse) and serialises it into 1/2/4/8 single-byte RAM accesses, little-endian.
//  For loads, assembles and sign/zero-extends the bytes into a 64-bit word.
//  Returns memory_done to the control unit and the execute FSM.
// PARAMETERS
//  ADDR_WIDTH  64  width of mem_addr; bits [ADDR_WIDTH-1:0] of addr are used, byte address arithmetic is modulo 2^ADDR_WIDTH
// PORTS
//  clk                in   1           system clock, all state updates on rising edge
//  reset              in   1           synchronous, active-high
//  memory_start       in   1           request strobe; sampled only in IDLE
//  sel_mem_operation  in   1           0 = load, 1 = store
//  sel_mem_size       in   2           0 byte, 1 half, 2 word, 3 double; n = 1<<size bytes
//  sel_mem_extension  in   3           load func3; bit2 = 1 zero-extend, 0 sign-extend
//  addr               in   64          byte address of least-significant byte
//  data_i             in   64          store data; low n bytes written
//  data_o             out  64          extended load result; valid when memory_done = 1, held until the next load completes
//  memory_done        out  1           one-cycle completion pulse
//  busy               out  1           high from the cycle after accept through the DONE cycle
//  mem_addr           out  ADDR_WIDTH  RAM byte address
//  mem_data_o         out  8           RAM write data
//  mem_data_i         in   8           RAM read data; valid the cycle after the RAM samples mem_addr with mem_re = 1
//  mem_we             out  1           RAM write enable
//  mem_re             out  1           RAM read enable
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: state = IDLE; data_o, mem_addr, mem_data_o = 0; memory_done, busy, mem_we, mem_re = 0.
//  - States: IDLE, READ, DRAIN, WRITE, DONE.
//  - IDLE:
//    - memory_start = 1 at edge T latches op, size, extension, addr, data_i; byte counter k = 0.
//    - Next state is READ (load) or WRITE (store).
//  - READ: cycles T+1..T+n.
//    - mem_re = 1, mem_addr = addr + k.
//    - Starting one cycle after the first issue, mem_data_i is captured into byte lane k-1 of the assembly register each cycle.
//    - After the n-th issue, go to DRAIN.
//  - DRAIN: one cycle.
//    - mem_re = 0; capture the final byte (n-1).
//    - At the edge ending DRAIN: data_o <= extended result, go to DONE.
//  - WRITE: cycles T+1..T+n.
//    - mem_we = 1, mem_addr = addr + k, mem_data_o = data_i[8k+7:8k].
//    - Go to DONE after byte n-1.
//  - DONE: memory_done = 1 for exactly one cycle, mem_we = mem_re = 0, then IDLE.
//  - Latency from the accepting edge T to the memory_done cycle:
//    - load: cycle T+n+2
//    - store: cycle T+n+1
//    - Next request is accepted at the earliest in the cycle after DONE.
//  - Extension:
//    - Bits above 8n are filled with bit 8n-1 when sel_mem_extension[2] = 0, else with 0.
//    - size 3 ignores extension.
//  - memory_start while busy (including the DONE cycle) is ignored; no queuing.
//  - Misaligned addresses are legal; bytes are accessed sequentially.
//  - Address wraps modulo 2^ADDR_WIDTH.
//  - Reset mid-operation: IDLE at the next edge, all strobes 0.
//    - Bytes already written stay written; no rollback.
//    - data_o cleared; no memory_done pulse.
//  - Loads never drive mem_we; stores never drive mem_re.
//  - data_o does not change on stores.
// TESTING
//  1. RAM[0x100..0x107] = 01..08; LD (size 3) at 0x100 -> data_o = 0x0807060504030201, memory_done in cycle T+10, exactly 8 mem_re cycles.
//  2. RAM[0x40] = 0x80: LB (ext 000) -> data_o = 0xFFFFFFFFFFFFFF80; LBU (ext 100) -> 0x0000000000000080; each done at T+3.
//  3. RAM word = 0x80000000 at 0x20: LW -> 0xFFFFFFFF80000000; LWU -> 0x0000000080000000.
//  4. SH data_i = 0xDEADBEEFCAFE1234 at 0x200 -> 0x34 @ 0x200, 0x12 @ 0x201, mem_we high 2 cycles, 0x202 untouched, done at T+3, data_o unchanged.
//  5. Second memory_start during a LD, then reset after 3 bytes read -> second request ignored; next cycle memory_done = busy = mem_re = 0, data_o = 0; new LB then completes normally.
//  6. ADDR_WIDTH = 16, SW 0x11223344 at 0xFFFE -> writes 44 @ FFFE, 33 @ FFFF, 22 @ 0000, 11 @ 0001.

Source files
------------

// File: rtl/memory_controller_if.sv
// memory_controller_if: core request/response and byte-RAM signals of the memory controller.
interface memory_controller_if #(parameter int ADDR_WIDTH = 64);
    logic                  memory_start;
    logic                  sel_mem_operation;
    logic [1:0]            sel_mem_size;
    logic [2:0]            sel_mem_extension;
    logic [63:0]           addr;
    logic [63:0]           data_i;
    logic [63:0]           data_o;
    logic                  memory_done;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_data_o;
    logic [7:0]            mem_data_i;
    logic                  mem_we;
    logic                  mem_re;
    modport master (
        output memory_start, sel_mem_operation, sel_mem_size, sel_mem_extension, addr, data_i, mem_data_i,
        input  data_o, memory_done, busy, mem_addr, mem_data_o, mem_we, mem_re
    );
    modport slave (
        input  memory_start, sel_mem_operation, sel_mem_size, sel_mem_extension, addr, data_i, mem_data_i,
        output data_o, memory_done, busy, mem_addr, mem_data_o, mem_we, mem_re
    );
endinterface

// File: rtl/memory_controller.sv
// memory_controller: serialises 1/2/4/8-byte loads and stores onto a byte-wide synchronous RAM, little-endian.
module memory_controller #(
    parameter int ADDR_WIDTH = 64
) (
    input logic                clk,
    input logic                reset,
    memory_controller_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;
    state_t      state;
    logic [1:0]  size_r;
    logic        zext_r;
    logic [63:0] data_r;
    logic [63:0] asm_r;
    logic [2:0]  k;
    logic [2:0]  last_k;
    logic [2:0]  lane;
    logic [5:0]  sign_idx;
    logic [63:0] asm_n;
    logic [63:0] mask;
    logic [63:0] ext_val;
    logic        fill;
    // read data lags the issue by one cycle, so READ fills lane k-1 and DRAIN fills the last lane
    always_comb begin
        last_k   = 3'((4'd1 << size_r) - 4'd1);
        lane     = (state == DRAIN) ? k : k - 3'd1;
        asm_n    = asm_r;
        asm_n[{lane, 3'b000} +: 8] = bus.mem_data_i;
        sign_idx = 6'((7'd8 << size_r) - 7'd1);
        fill     = ~zext_r & asm_n[sign_idx];
        mask     = ~(64'hFFFF_FFFF_FFFF_FFFF << (7'd8 << size_r));
        ext_val  = (asm_n & mask) | ({64{fill}} & ~mask);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            size_r          <= '0;
            zext_r          <= 1'b0;
            data_r          <= '0;
            asm_r           <= '0;
            k               <= '0;
            bus.data_o      <= '0;
            bus.memory_done <= 1'b0;
            bus.busy        <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_data_o  <= '0;
            bus.mem_we      <= 1'b0;
            bus.mem_re      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.memory_start) begin
                    size_r         <= bus.sel_mem_size;
                    zext_r         <= bus.sel_mem_extension[2];
                    data_r         <= bus.data_i;
                    asm_r          <= '0;
                    k              <= '0;
                    bus.busy       <= 1'b1;
                    bus.mem_addr   <= bus.addr[ADDR_WIDTH-1:0];
                    bus.mem_data_o <= bus.data_i[7:0];
                    bus.mem_we     <= bus.sel_mem_operation;
                    bus.mem_re     <= ~bus.sel_mem_operation;
                    state          <= bus.sel_mem_operation ? WRITE : READ;
                end
                READ: begin
                    if (k != 3'd0) asm_r <= asm_n;
                    if (k == last_k) begin
                        bus.mem_re <= 1'b0;
                        state      <= DRAIN;
                    end else begin
                        k            <= k + 3'd1;
                        bus.mem_addr <= bus.mem_addr + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    bus.data_o      <= ext_val;
                    bus.memory_done <= 1'b1;
                    state           <= DONE;
                end
                WRITE: if (k == last_k) begin
                    bus.mem_we      <= 1'b0;
                    bus.memory_done <= 1'b1;
                    state           <= DONE;
                end else begin
                    k              <= k + 3'd1;
                    bus.mem_addr   <= bus.mem_addr + ADDR_WIDTH'(1);
                    bus.mem_data_o <= data_r[15:8];
                    data_r         <= data_r >> 8;
                end
                DONE: begin
                    bus.memory_done <= 1'b0;
                    bus.busy        <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller: directed checks of loads, stores, extension, reset abort and address wrap.
module tb_memory_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc, re_n, we_n;
    logic [7:0] ram   [0:65535];
    logic [7:0] ram16 [0:65535];

    memory_controller_if #(.ADDR_WIDTH(64)) ba ();
    memory_controller_if #(.ADDR_WIDTH(16)) bb ();

    memory_controller #(.ADDR_WIDTH(64)) dut_a (.clk(clk), .reset(reset), .bus(ba));
    memory_controller #(.ADDR_WIDTH(16)) dut_b (.clk(clk), .reset(reset), .bus(bb));

    always #5 clk = ~clk;

    // byte RAMs: read data appears the cycle after the request; A is preloaded while reset is high
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) ram[16'h100 + i] <= 8'(i + 1);
            ram[16'h40] <= 8'h80;
            ram[16'h20] <= 8'h00;
            ram[16'h21] <= 8'h00;
            ram[16'h22] <= 8'h00;
            ram[16'h23] <= 8'h80;
            ram[16'h202] <= 8'hAA;
        end else if (ba.mem_we) begin
            ram[ba.mem_addr[15:0]] <= ba.mem_data_o;
        end
        if (ba.mem_re) ba.mem_data_i <= ram[ba.mem_addr[15:0]];
        if (bb.mem_we) ram16[bb.mem_addr] <= bb.mem_data_o;
        if (bb.mem_re) bb.mem_data_i <= ram16[bb.mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic op, input logic [1:0] size, input logic [2:0] ext,
                            input logic [63:0] a, input logic [63:0] d);
        @(negedge clk);
        ba.memory_start      = 1'b1;
        ba.sel_mem_operation = op;
        ba.sel_mem_size      = size;
        ba.sel_mem_extension = ext;
        ba.addr              = a;
        ba.data_i            = d;
        @(negedge clk);
        ba.memory_start = 1'b0;
    endtask

    // called in cycle T+1; returns the offset of the memory_done cycle from accepting edge T
    task automatic wait_done(output int c, output int r, output int w);
        c = 1; r = 0; w = 0;
        while (!ba.memory_done && c < 40) begin
            r += int'(ba.mem_re);
            w += int'(ba.mem_we);
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        ba.memory_start = 0; ba.sel_mem_operation = 0; ba.sel_mem_size = 0;
        ba.sel_mem_extension = 0; ba.addr = 0; ba.data_i = 0;
        bb.memory_start = 0; bb.sel_mem_operation = 0; bb.sel_mem_size = 0;
        bb.sel_mem_extension = 0; bb.addr = 0; bb.data_i = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_data_o", ba.data_o, 0);
        chk("rst_done", 64'(ba.memory_done), 0);
        chk("rst_busy", 64'(ba.busy), 0);
        chk("rst_we_re", 64'({ba.mem_we, ba.mem_re}), 0);
        chk("rst_mem_addr", ba.mem_addr, 0);
        chk("rst_mem_data_o", 64'(ba.mem_data_o), 0);

        start_op(0, 2'd3, 3'b011, 64'h100, 0);
        chk("ld_busy_t1", 64'(ba.busy), 1);
        wait_done(cyc, re_n, we_n);
        chk("ld_latency", 64'(cyc), 10);
        chk("ld_re_cycles", 64'(re_n), 8);
        chk("ld_we_cycles", 64'(we_n), 0);
        chk("ld_data", ba.data_o, 64'h0807060504030201);
        chk("ld_busy_done", 64'(ba.busy), 1);
        @(negedge clk);
        chk("ld_done_pulse", 64'(ba.memory_done), 0);
        chk("ld_busy_after", 64'(ba.busy), 0);

        start_op(0, 2'd0, 3'b000, 64'h40, 0);
        wait_done(cyc, re_n, we_n);
        chk("lb_latency", 64'(cyc), 3);
        chk("lb_data", ba.data_o, 64'hFFFFFFFFFFFFFF80);
        start_op(0, 2'd0, 3'b100, 64'h40, 0);
        wait_done(cyc, re_n, we_n);
        chk("lbu_latency", 64'(cyc), 3);
        chk("lbu_data", ba.data_o, 64'h0000000000000080);

        start_op(0, 2'd2, 3'b010, 64'h20, 0);
        wait_done(cyc, re_n, we_n);
        chk("lw_latency", 64'(cyc), 6);
        chk("lw_data", ba.data_o, 64'hFFFFFFFF80000000);
        start_op(0, 2'd2, 3'b110, 64'h20, 0);
        wait_done(cyc, re_n, we_n);
        chk("lwu_data", ba.data_o, 64'h0000000080000000);

        start_op(0, 2'd1, 3'b001, 64'h103, 0);
        wait_done(cyc, re_n, we_n);
        chk("lh_misaligned_latency", 64'(cyc), 4);
        chk("lh_misaligned_data", ba.data_o, 64'h0000000000000504);

        start_op(0, 2'd2, 3'b110, 64'h20, 0);
        wait_done(cyc, re_n, we_n);
        start_op(1, 2'd1, 3'b000, 64'h200, 64'hDEADBEEFCAFE1234);
        wait_done(cyc, re_n, we_n);
        chk("sh_latency", 64'(cyc), 3);
        chk("sh_we_cycles", 64'(we_n), 2);
        chk("sh_re_cycles", 64'(re_n), 0);
        chk("sh_byte0", 64'(ram[16'h200]), 64'h34);
        chk("sh_byte1", 64'(ram[16'h201]), 64'h12);
        chk("sh_byte2_untouched", 64'(ram[16'h202]), 64'hAA);
        chk("sh_data_o_kept", ba.data_o, 64'h0000000080000000);

        @(negedge clk);
        ba.memory_start = 1; ba.sel_mem_operation = 0; ba.sel_mem_size = 3;
        ba.sel_mem_extension = 0; ba.addr = 64'h100;
        @(negedge clk);
        ba.sel_mem_operation = 1; ba.addr = 64'h300; ba.data_i = 64'h55;
        chk("abort_t1_re", 64'({ba.mem_we, ba.mem_re}), 1);
        @(negedge clk);
        ba.memory_start = 0;
        chk("abort_t2_addr", ba.mem_addr, 64'h101);
        chk("abort_t2_re", 64'({ba.mem_we, ba.mem_re}), 1);
        @(negedge clk);
        chk("abort_t3_addr", ba.mem_addr, 64'h102);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_done", 64'(ba.memory_done), 0);
        chk("abort_busy", 64'(ba.busy), 0);
        chk("abort_strobes", 64'({ba.mem_we, ba.mem_re}), 0);
        chk("abort_data_o", ba.data_o, 0);
        reset = 1'b0;
        start_op(0, 2'd0, 3'b000, 64'h40, 0);
        wait_done(cyc, re_n, we_n);
        chk("post_abort_lb_latency", 64'(cyc), 3);
        chk("post_abort_lb_data", ba.data_o, 64'hFFFFFFFFFFFFFF80);

        @(negedge clk);
        bb.memory_start = 1; bb.sel_mem_operation = 1; bb.sel_mem_size = 2;
        bb.addr = 64'hFFFE; bb.data_i = 64'h11223344;
        @(negedge clk);
        bb.memory_start = 0;
        cyc = 1; we_n = 0;
        while (!bb.memory_done && cyc < 40) begin
            we_n += int'(bb.mem_we);
            @(negedge clk);
            cyc++;
        end
        chk("wrap_latency", 64'(cyc), 5);
        chk("wrap_we_cycles", 64'(we_n), 4);
        chk("wrap_fffe", 64'(ram16[16'hFFFE]), 64'h44);
        chk("wrap_ffff", 64'(ram16[16'hFFFF]), 64'h33);
        chk("wrap_0000", 64'(ram16[16'h0000]), 64'h22);
        chk("wrap_0001", 64'(ram16[16'h0001]), 64'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
